serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/full_subtractor.sv | 26 ++
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   sub_state_t : control FSM encoding (IDLE, SHIFT, DONE)
//   MAX_WIDTH   : largest supported operand width
//   cnt_width() : bit counter width for a given operand width (minimum 1)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int MAX_WIDTH = 32;

  // $clog2(1) is 0, which would give a zero-width counter; clamp to 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor: D = A - B - Bin.
// Ports:
//   A    : minuend bit
//   B    : subtrahend bit
//   Bin  : borrow in
//   D    : difference bit
//   Bout : borrow out (set when A < B + Bin)
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign D       = a_xor_b ^ Bin;
  // Borrow when B alone exceeds A, or when A == B and a borrow arrives.
  assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: Diff = (A - B - Bin) mod 2^WIDTH, LSB first,
// one bit per clock, using a single borrow flop.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   start : request; accepted only in IDLE or DONE
//   A, B  : operands, captured on an accepted start
//   Bin   : borrow in, captured on an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when Diff/Bout are updated
//   Diff  : registered result, held until the next result
//   Bout  : registered borrow out, 1 iff A < B + Bin
// Timing: start sampled at E0, bits at E1..E_WIDTH, done in the cycle after
// E_WIDTH. A start seen in the DONE cycle launches the next operation without
// an idle bubble, so throughput is one result per WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH must be in 1..%0d", MAX_WIDTH);
  end

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;
  logic             accept;

  // Per-bit arithmetic on the current LSBs and the running borrow.
  full_subtractor u_fs (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (br_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    // New bit enters at the MSB; written as shift-then-set so WIDTH=1 works.
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fs_d;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bout;
        res_d = res_shift;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full result including this bit.
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = fs_bout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: all datapath registers are reset, not just control, so that an
      // aborted operation leaves no stale operand or partial result behind.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed self-checking bench for serial_subtractor at WIDTH=4.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at
// that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic bi);
    start = s;
    a     = av;
    b     = bv;
    bin   = bi;
  endtask

  // Launch from IDLE, confirm four busy cycles, then check the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic bi,
                        input logic [W-1:0] exp_diff, input logic exp_bout);
    drive(1'b1, av, bv, bi);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    check({tag, "_diff"}, {28'd0, diff}, {28'd0, exp_diff});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
  endtask

  initial begin
    logic [4:0] ref5;

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset state, with start asserted to show reset wins.
    start = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {28'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 9 - 3 = 6, no borrow.
    run_op("op_9_3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

    // 3 - 9 = -6 -> 0xA with borrow; result holds afterwards.
    run_op("op_3_9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    tick();
    check("hold_done", {31'd0, done}, 32'd0);
    check("hold_diff", {28'd0, diff}, 32'hA);
    check("hold_bout", {31'd0, bout}, 32'd1);
    tick();
    tick();
    check("hold2_diff", {28'd0, diff}, 32'hA);

    // Borrow-in with equal operands gives all ones and a borrow.
    run_op("op_0_0_1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    run_op("op_f_f_1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    tick();

    // Start held high during busy with changing operands is ignored;
    // 12 - 5 = 7 must come out intact.
    drive(1'b1, 4'd12, 4'd5, 1'b0);
    tick();
    drive(1'b1, 4'd1, 4'd14, 1'b1);
    tick();
    drive(1'b1, 4'd8, 4'd8, 1'b1);
    tick();
    tick();
    check("ign_busy", {31'd0, busy}, 32'd1);
    // Diff still holds the previous result during the new operation.
    check("ign_hold", {28'd0, diff}, 32'hF);
    tick();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_diff", {28'd0, diff}, 32'd7);
    check("ign_bout", {31'd0, bout}, 32'd0);

    // Start in the DONE cycle: 7 - 2 = 5, done exactly 5 cycles later.
    drive(1'b1, 4'd7, 4'd2, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < W - 1; i++) begin
      tick();
      check("b2b_nodone", {31'd0, done}, 32'd0);
    end
    tick();
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_diff", {28'd0, diff}, 32'd5);
    check("b2b_bout", {31'd0, bout}, 32'd0);
    tick();

    // Reset mid-operation: start at E0, reset sampled at E2.
    drive(1'b1, 4'd9, 4'd3, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {28'd0, diff}, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_nodone", {31'd0, done}, 32'd0);
    end

    // Exhaustive back-to-back sweep: start stays high, so each DONE cycle
    // immediately accepts the next operand set.
    for (int v = 0; v < 512; v++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         bi;
      av   = v[3:0];
      bv   = v[7:4];
      bi   = v[8];
      ref5 = {1'b0, av} - {1'b0, bv} - {4'd0, bi};
      drive(1'b1, av, bv, bi);
      tick();
      for (int i = 0; i < W; i++) tick();
      check("sweep_done", {31'd0, done}, 32'd1);
      check("sweep_diff", {28'd0, diff}, {28'd0, ref5[3:0]});
      check("sweep_bout", {31'd0, bout}, {31'd0, ref5[4]});
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("end_idle_done", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
